excp_csr_unit: RTL
==================

EXCP_CSR_UNIT -- requirements
Module: excp_csr_unit

Interface
REQ-001 SHALL have these ports (name direction width meaning):
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- excp_flush  in  1  commit-stage exception.
- ertn_flush  in  1  commit-stage ertn.
- csr_era  in  32  faulting PC.
- csr_ecode  in  6  exception code.
- csr_esubcode  in  9  exception subcode.
- va_error  in  1  BADV update enable.
- bad_va  in  32  faulting address.
- excp_tlbrefill  in  1  TLB refill exception.
- excp_tlb  in  1  TLB-class exception.
- excp_tlb_vppn  in  19  faulting VPPN.
- csr_w_0, csr_w_1  in  csr_write_signal  lane 0/1 CSR writes (fields we, addr[13:0], data[31:0]).
- hw_int  in  8  hardware interrupt lines.
- ti  in  1  timer interrupt.
- ipi  in  1  inter-processor interrupt.
- raddr  in  14  CSR read address.
- rdata  out  32  CSR read data.
- redirect_valid  out  1  fetch redirect pulse.
- redirect_pc  out  32  redirect target.
- int_req  out  1  interrupt request to decode.
- crmd_plv  out  2  current privilege level.
- crmd_da, crmd_pg  out  1 each  translation mode.
REQ-002 SHALL use one clock (clk); reset (rst) is synchronous and active-high.

Function
REQ-003 SHALL implement these CSRs (address: writable bits): CRMD 0x0: [8:0]; PRMD 0x1: [2:0]; ECFG 0x4: LIE [12:0] except bit 10; ESTAT 0x5: IS[1:0]; ERA 0x6: [31:0]; BADV 0x7: [31:0]; EENTRY 0xC: [31:6]; TLBEHI 0x11: [31:13]; TLBRENTRY 0x88: [31:6].
REQ-004 SHALL drive rdata combinationally from current register state; unimplemented addresses read 0; no write forwarding.
REQ-005 SHALL apply software writes at posedge when we=1, lane 0 before lane 1; lane 1 wins on the same address; non-writable bits are unchanged.
REQ-006 SHALL ignore both software write lanes in any cycle where excp_flush or ertn_flush is 1.
REQ-007 On excp_flush, at the next edge:
- PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE; CRMD.PLV<=0; CRMD.IE<=0.
- ERA<=csr_era; ESTAT.Ecode<=csr_ecode; ESTAT.EsubCode<=csr_esubcode.
- BADV<=bad_va only if va_error=1.
- TLBEHI.VPPN<=excp_tlb_vppn only if excp_tlb=1.
- If excp_tlbrefill=1: CRMD.DA<=1 and CRMD.PG<=0.
REQ-008 On ertn_flush (and excp_flush=0), at the next edge:
- CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE.
- If ESTAT.Ecode==0x3F (TLBR): CRMD.DA<=0 and CRMD.PG<=1.
REQ-009 SHALL give excp_flush priority when excp_flush and ertn_flush are asserted together; ertn effects are dropped.
REQ-010 SHALL assert redirect_valid exactly one cycle after each flush cycle, for one cycle. redirect_pc SHALL be TLBRENTRY for a refill, EENTRY for other exceptions, and the pre-update ERA for ertn; latency is 1 cycle.
REQ-011 Back-to-back flush cycles SHALL produce back-to-back redirect pulses, each reflecting its own cause.
REQ-012 SHALL sample ESTAT.IS[9:2]<=hw_int, IS[11]<=ti, IS[12]<=ipi every cycle; IS[10]=0.
REQ-013 SHALL register int_req <= CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), giving one cycle of latency from register state.
REQ-014 crmd_plv, crmd_da and crmd_pg SHALL be direct register outputs.

Reset
REQ-015 On rst:
- CRMD=0x0000_0008 (DA=1); all other CSRs=0.
- redirect_valid=0; redirect_pc=0; int_req=0.
REQ-016 A flush or write coincident with rst SHALL be discarded.

Structure
REQ-017 CSR address constants, ECODE/ESUBCODE constants and the csr_write_signal typedef SHALL live in the shared pipeline defines package.
REQ-018 SHALL instantiate one sub-module, csr_int_ctrl, holding ESTAT.IS sampling and int_req generation; all other logic SHALL be in the top.

Verification
REQ-019 Set EENTRY=0x1C00_8000 and CRMD.PLV=3, IE=1; pulse excp_flush with csr_era=0x1C00_0100, ecode=0xB -> next cycle redirect_pc=0x1C00_8000; ERA=0x1C00_0100; PRMD=0x7; CRMD.PLV=0, IE=0.
REQ-020 From the REQ-019 state, pulse ertn_flush -> redirect_pc=0x1C00_0100; CRMD.PLV=3, IE=1.
REQ-021 Set TLBRENTRY=0x1C00_F000; pulse a refill with ecode=0x3F, vppn=0x12345 -> redirect_pc=0x1C00_F000; DA=1, PG=0; TLBEHI=0x2468_A000; then ertn -> DA=0, PG=1.
REQ-022 Assert excp_flush and ertn_flush together, plus lane 0/1 writes to ERA -> exception semantics only; ERA=csr_era; software writes dropped.
REQ-023 Set ECFG.LIE=0x800 and CRMD.IE=1; raise ti -> int_req=1 two cycles later; clear IE -> int_req=0 one cycle later.
REQ-024 Write ERA from both lanes with data 0x1 and 0x2 -> ERA=0x2; apply rst mid-flush -> redirect_valid=0 and CRMD=0x8.

Source files
------------

// File: rtl/excp_csr_unit_pkg.sv
// rtl/excp_csr_unit_pkg.sv - shared pipeline defines: CSR addresses, exception codes, CSR write lane type
package excp_csr_unit_pkg;

    localparam logic [13:0] CSR_CRMD      = 14'h000;
    localparam logic [13:0] CSR_PRMD      = 14'h001;
    localparam logic [13:0] CSR_ECFG      = 14'h004;
    localparam logic [13:0] CSR_ESTAT     = 14'h005;
    localparam logic [13:0] CSR_ERA       = 14'h006;
    localparam logic [13:0] CSR_BADV      = 14'h007;
    localparam logic [13:0] CSR_EENTRY    = 14'h00C;
    localparam logic [13:0] CSR_TLBEHI    = 14'h011;
    localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

    localparam logic [31:0] MASK_CRMD      = 32'h0000_01FF;
    localparam logic [31:0] MASK_PRMD      = 32'h0000_0007;
    localparam logic [31:0] MASK_ECFG      = 32'h0000_1BFF;
    localparam logic [31:0] MASK_ERA       = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_BADV      = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_EENTRY    = 32'hFFFF_FFC0;
    localparam logic [31:0] MASK_TLBEHI    = 32'hFFFF_E000;
    localparam logic [31:0] MASK_TLBRENTRY = 32'hFFFF_FFC0;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [31:0] data;
    } csr_write_signal;

    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/csr_int_ctrl.sv
// rtl/csr_int_ctrl.sv - ESTAT.IS hardware sampling and registered interrupt request
module csr_int_ctrl
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_hw_int,
    input  logic        i_ti,
    input  logic        i_ipi,
    input  logic [1:0]  i_is_sw,
    input  logic        i_crmd_ie,
    input  logic [12:0] i_ecfg_lie,
    output logic [12:2] o_is_hw,
    output logic        o_int_req
);
    logic [12:2] r_is_hw;
    logic        r_int_req;
    logic [12:0] w_is;

    assign w_is = {r_is_hw, i_is_sw};

    // Request is built from registered IS, so a new line shows up on int_req two edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_hw   <= '0;
            r_int_req <= 1'b0;
        end else begin
            r_is_hw   <= {i_ipi, i_ti, 1'b0, i_hw_int};
            r_int_req <= i_crmd_ie & (|(w_is & i_ecfg_lie));
        end
    end

    assign o_is_hw   = r_is_hw;
    assign o_int_req = r_int_req;

endmodule

// File: rtl/excp_csr_unit.sv
// rtl/excp_csr_unit.sv - exception/ertn CSR state, software CSR writes and fetch redirect
module excp_csr_unit
    import excp_csr_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            excp_flush,
    input  logic            ertn_flush,
    input  logic [31:0]     csr_era,
    input  logic [5:0]      csr_ecode,
    input  logic [8:0]      csr_esubcode,
    input  logic            va_error,
    input  logic [31:0]     bad_va,
    input  logic            excp_tlbrefill,
    input  logic            excp_tlb,
    input  logic [18:0]     excp_tlb_vppn,
    input  csr_write_signal csr_w_0,
    input  csr_write_signal csr_w_1,
    input  logic [7:0]      hw_int,
    input  logic            ti,
    input  logic            ipi,
    input  logic [13:0]     raddr,
    output logic [31:0]     rdata,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    output logic            int_req,
    output logic [1:0]      crmd_plv,
    output logic            crmd_da,
    output logic            crmd_pg
);
    logic [31:0] r_crmd, r_prmd, r_ecfg, r_era, r_badv, r_eentry, r_tlbehi, r_tlbrentry;
    logic [1:0]  r_estat_sw;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;

    logic [31:0] w_crmd_nxt, w_prmd_nxt, w_ecfg_nxt, w_era_nxt, w_badv_nxt;
    logic [31:0] w_eentry_nxt, w_tlbehi_nxt, w_tlbrentry_nxt;
    logic [1:0]  w_estat_sw_nxt;
    logic [5:0]  w_ecode_nxt;
    logic [8:0]  w_esubcode_nxt;
    logic [12:2] w_is_hw;
    logic [31:0] w_estat;
    csr_write_signal w_lane [2];

    assign w_lane[0] = csr_w_0;
    assign w_lane[1] = csr_w_1;
    assign w_estat   = {1'b0, r_esubcode, r_ecode, 3'b000, w_is_hw, r_estat_sw};

    always_comb begin
        w_crmd_nxt      = r_crmd;
        w_prmd_nxt      = r_prmd;
        w_ecfg_nxt      = r_ecfg;
        w_era_nxt       = r_era;
        w_badv_nxt      = r_badv;
        w_eentry_nxt    = r_eentry;
        w_tlbehi_nxt    = r_tlbehi;
        w_tlbrentry_nxt = r_tlbrentry;
        w_estat_sw_nxt  = r_estat_sw;
        w_ecode_nxt     = r_ecode;
        w_esubcode_nxt  = r_esubcode;
        if (excp_flush) begin
            w_prmd_nxt      = {29'b0, r_crmd[2:0]};
            w_crmd_nxt[2:0] = 3'b000;
            if (excp_tlbrefill) begin
                w_crmd_nxt[3] = 1'b1;
                w_crmd_nxt[4] = 1'b0;
            end
            w_era_nxt      = csr_era;
            w_ecode_nxt    = csr_ecode;
            w_esubcode_nxt = csr_esubcode;
            if (va_error) w_badv_nxt = bad_va;
            if (excp_tlb) w_tlbehi_nxt = {excp_tlb_vppn, 13'b0};
        end else if (ertn_flush) begin
            w_crmd_nxt[2:0] = r_prmd[2:0];
            if (r_ecode == ECODE_TLBR) begin
                w_crmd_nxt[3] = 1'b0;
                w_crmd_nxt[4] = 1'b1;
            end
        end else begin
            // Lanes applied in order so lane 1 overrides lane 0 on a shared address.
            for (int i = 0; i < 2; i++) begin
                if (w_lane[i].we) begin
                    case (w_lane[i].addr)
                        CSR_CRMD:      w_crmd_nxt      = csr_merge(w_crmd_nxt, w_lane[i].data, MASK_CRMD);
                        CSR_PRMD:      w_prmd_nxt      = csr_merge(w_prmd_nxt, w_lane[i].data, MASK_PRMD);
                        CSR_ECFG:      w_ecfg_nxt      = csr_merge(w_ecfg_nxt, w_lane[i].data, MASK_ECFG);
                        CSR_ESTAT:     w_estat_sw_nxt  = w_lane[i].data[1:0];
                        CSR_ERA:       w_era_nxt       = csr_merge(w_era_nxt, w_lane[i].data, MASK_ERA);
                        CSR_BADV:      w_badv_nxt      = csr_merge(w_badv_nxt, w_lane[i].data, MASK_BADV);
                        CSR_EENTRY:    w_eentry_nxt    = csr_merge(w_eentry_nxt, w_lane[i].data, MASK_EENTRY);
                        CSR_TLBEHI:    w_tlbehi_nxt    = csr_merge(w_tlbehi_nxt, w_lane[i].data, MASK_TLBEHI);
                        CSR_TLBRENTRY: w_tlbrentry_nxt = csr_merge(w_tlbrentry_nxt, w_lane[i].data, MASK_TLBRENTRY);
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crmd           <= 32'h0000_0008;
            r_prmd           <= '0;
            r_ecfg           <= '0;
            r_era            <= '0;
            r_badv           <= '0;
            r_eentry         <= '0;
            r_tlbehi         <= '0;
            r_tlbrentry      <= '0;
            r_estat_sw       <= '0;
            r_ecode          <= '0;
            r_esubcode       <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_crmd           <= w_crmd_nxt;
            r_prmd           <= w_prmd_nxt;
            r_ecfg           <= w_ecfg_nxt;
            r_era            <= w_era_nxt;
            r_badv           <= w_badv_nxt;
            r_eentry         <= w_eentry_nxt;
            r_tlbehi         <= w_tlbehi_nxt;
            r_tlbrentry      <= w_tlbrentry_nxt;
            r_estat_sw       <= w_estat_sw_nxt;
            r_ecode          <= w_ecode_nxt;
            r_esubcode       <= w_esubcode_nxt;
            r_redirect_valid <= excp_flush | ertn_flush;
            // Targets come from pre-update state; ertn returns to the ERA held before this edge.
            if (excp_flush)
                r_redirect_pc <= excp_tlbrefill ? r_tlbrentry : r_eentry;
            else if (ertn_flush)
                r_redirect_pc <= r_era;
        end
    end

    csr_int_ctrl u_int_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_hw_int   (hw_int),
        .i_ti       (ti),
        .i_ipi      (ipi),
        .i_is_sw    (r_estat_sw),
        .i_crmd_ie  (r_crmd[2]),
        .i_ecfg_lie (r_ecfg[12:0]),
        .o_is_hw    (w_is_hw),
        .o_int_req  (int_req)
    );

    always_comb begin
        rdata = '0;
        case (raddr)
            CSR_CRMD:      rdata = r_crmd;
            CSR_PRMD:      rdata = r_prmd;
            CSR_ECFG:      rdata = r_ecfg;
            CSR_ESTAT:     rdata = w_estat;
            CSR_ERA:       rdata = r_era;
            CSR_BADV:      rdata = r_badv;
            CSR_EENTRY:    rdata = r_eentry;
            CSR_TLBEHI:    rdata = r_tlbehi;
            CSR_TLBRENTRY: rdata = r_tlbrentry;
            default:       rdata = '0;
        endcase
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign crmd_plv       = r_crmd[1:0];
    assign crmd_da        = r_crmd[3];
    assign crmd_pg        = r_crmd[4];

endmodule
